remote_receiver: RTL and testbench
==================================

# remote_receiver

Serial-to-parallel receiver for the remote link; sits directly downstream of `transmitter` and consumes its `serial_data` line. It detects a frame start, samples each bit slot at mid-slot, checks parity and stop, and presents the recovered 5-bit code on `data_out` with a one-cycle `data_valid` strobe. Malformed frames are dropped and flagged on `frame_err`.

## Interface
- `BIT_TICKS`, 16, clock cycles per bit slot; even, 4..256
- `DATA_W`, 5, payload width; matches the transmitter's `data`
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `serial_in`  in  1  serial line from `transmitter.serial_data`; asynchronous to `clk`
- `data_out`  out  DATA_W  last good payload; holds until next good frame
- `data_valid`  out  1  one-cycle pulse, `data_out` updated same cycle
- `frame_err`  out  1  one-cycle pulse on parity or stop failure
- `busy`  out  1  high while a frame is being received (state != IDLE)

## Operation
- Frame format (one slot = BIT_TICKS cycles): idle low; start slot 1; data bits 0..DATA_W-1 LSB first; even-parity slot (XOR of the data bits); stop slot 0. Total 8 slots at DATA_W=5.
- `serial_in` passes through a 2-flop synchronizer (reset value 0) to give `s`; `s_prev` holds the previous `s`. Rise = `s & ~s_prev`.
- Tick counter `tick` (width ceil(log2(BIT_TICKS))) and bit index `idx` (0..DATA_W-1).
- States:
  - IDLE: on rise, go to START, tick <= 1. Otherwise stay.
  - START: when tick == BIT_TICKS/2 - 1 (sample point H): if `s`=1, go to DATA, tick <= 0, idx <= 0; if `s`=0, glitch, return to IDLE silently (no `frame_err`).
  - DATA: when tick == BIT_TICKS-1, shift `s` into bit `idx` of the shift register, tick <= 0; after idx == DATA_W-1 go to PARITY, else idx+1.
  - PARITY: when tick == BIT_TICKS-1, capture `s` as parity bit, go to STOP.
  - STOP: when tick == BIT_TICKS-1, evaluate: stop `s`=0 and XOR(shift, parity)=0 → register `data_out` <= shift, `data_valid` <= 1; else `frame_err` <= 1, `data_out` unchanged. Go to IDLE.
- The counter otherwise increments by 1 per cycle in every non-IDLE state.
- Re-arm needs a fresh rise: if the line stays high after a bad stop, no new frame starts until it returns low and rises again.
- `data_valid` and `frame_err` are never high in the same cycle and are each high for exactly one cycle.
- Reset: state IDLE, tick/idx/shift 0, sync flops 0, `data_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0. Reset asserted mid-frame aborts the frame with no strobe. The frame is not recovered after reset is released; the line must go low and rise again.

## Timing
- Let E be the cycle in which rise is seen (raw edge sampled at cycle T gives E = T+2).
- Start sample at E+H, with H = BIT_TICKS/2. Data bit i is sampled at E+H+(i+1)·BIT_TICKS. Parity is sampled at E+H+6·BIT_TICKS and stop at E+H+7·BIT_TICKS.
- `data_valid`/`frame_err` are high in cycle E+H+7·BIT_TICKS+1. For BIT_TICKS=16 that is E+121, or T+123 from the raw edge.
- `busy` rises at E+1 and falls in the same cycle as the strobe.
- Back-to-back frames: the next start rise may occur as early as one cycle after the stop slot ends. The receiver is in IDLE from the strobe cycle onward.
- Glitch tolerance: high pulses shorter than H cycles on an idle line are rejected.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `serial_in`=1 → all outputs 0, `busy`=0. Release with line low → no strobe.
- Good frame 5'b10110 (parity 1), BIT_TICKS=16 → `data_valid` pulse at T+123 and `data_out`=5'b10110. Repeat with 5'b00000 and 5'b11111 → correct values, one pulse each.
- Parity error: send 5'b00011 with parity slot 1 → `frame_err` pulse at T+123, no `data_valid`, `data_out` keeps the previous value.
- Stop error: send a valid frame with stop slot held 1 → `frame_err`. The line then stays high for 50 cycles → no new frame. Next clean frame 5'b01001 → `data_valid`, `data_out`=5'b01001.
- Glitch and abort: a 5-cycle high pulse on an idle line → `busy` returns to 0 with no strobe. Reset asserted during data bit 3 → no strobe and state IDLE. The following frame 5'b00101 → received correctly.
- Back-to-back: drive 4 frames from the `transmitter` model with no idle gap → 4 `data_valid` pulses exactly 8·BIT_TICKS cycles apart, each with the correct data.

Source files
------------

// File: rtl/remote_receiver.sv
// Serial frame receiver: start/data/parity/stop slots sampled at mid-slot,
// good payloads strobed on o_data_valid, malformed frames flagged on o_frame_err.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line idle, waiting for a synchronized rising edge
// S_START  | counting to half a slot to confirm the start bit
// S_DATA   | sampling payload bits LSB first, one per slot
// S_PARITY | sampling the even-parity slot
// S_STOP   | sampling the stop slot, then strobing valid or error
module remote_receiver #(
   parameter int BIT_TICKS = 16,
   parameter int DATA_W    = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_serial_in,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_data_valid,
   output logic              o_frame_err,
   output logic              o_busy
);

   localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TW-1:0] TICK_HALF = TW'(BIT_TICKS / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            r_state;
   logic              r_sync1;
   logic              r_s;
   logic              r_s_prev;
   logic [TW-1:0]     r_tick;
   logic [IW-1:0]     r_idx;
   logic [DATA_W-1:0] r_shift;
   logic              r_parity;
   logic [DATA_W-1:0] r_data_out;
   logic              r_data_valid;
   logic              r_frame_err;
   logic              r_busy;
   logic              w_rise;

   assign w_rise       = r_s & ~r_s_prev;
   assign o_data_out   = r_data_out;
   assign o_data_valid = r_data_valid;
   assign o_frame_err  = r_frame_err;
   assign o_busy       = r_busy;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_sync1      <= 1'b0;
         r_s          <= 1'b0;
         r_s_prev     <= 1'b0;
         r_tick       <= '0;
         r_idx        <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_sync1      <= i_serial_in;
         r_s          <= r_sync1;
         r_s_prev     <= r_s;
         r_data_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_START;
                  r_tick  <= TW'(1);
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (r_tick == TICK_HALF) begin
                  r_tick <= '0;
                  r_idx  <= '0;
                  // A start bit that is gone by mid-slot is treated as noise.
                  if (r_s) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            S_DATA: begin
               if (r_tick == TICK_LAST) begin
                  r_shift[r_idx] <= r_s;
                  r_tick         <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_state <= S_PARITY;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            S_PARITY: begin
               if (r_tick == TICK_LAST) begin
                  r_parity <= r_s;
                  r_tick   <= '0;
                  r_state  <= S_STOP;
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            S_STOP: begin
               if (r_tick == TICK_LAST) begin
                  if (!r_s && ((^r_shift) == r_parity)) begin
                     r_data_out   <= r_shift;
                     r_data_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
                  r_tick  <= '0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_remote_receiver.sv
// Bench for remote_receiver: a transmitter model drives frames and pushes the
// expected strobe (kind, payload, cycle) to a scoreboard checked by a monitor.
module tb_remote_receiver;

   localparam int BT  = 16;
   localparam int DW  = 5;
   // Strobe is registered on edge T+122 after the line is driven just after
   // edge T, so it occupies the cycle ending at edge T+123.
   localparam int LAT = 122;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          serial_in = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          frame_err;
   logic          busy;

   remote_receiver #(.BIT_TICKS(BT), .DATA_W(DW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_serial_in  (serial_in),
      .o_data_out   (data_out),
      .o_data_valid (data_valid),
      .o_frame_err  (frame_err),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit            is_err;
      logic [DW-1:0] data;
      int            at;
   } exp_t;

   exp_t          sb[$];
   exp_t          m_e;
   logic [DW-1:0] last_good = '0;
   bit            prev_strobe = 1'b0;
   int            n_chk = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input bit flip_par, input bit stop_v);
      logic [7:0] slots;
      exp_t       e;
      bit         good;
      good     = !flip_par && !stop_v;
      e.is_err = !good;
      e.data   = good ? d : last_good;
      e.at     = cyc + LAT;
      sb.push_back(e);
      if (good) last_good = d;
      slots = {stop_v, (^d) ^ flip_par, d, 1'b1};
      for (int i = 0; i < 8; i++) begin
         serial_in = slots[i];
         step(BT);
      end
   endtask

   always @(negedge clk) begin
      if (data_valid || frame_err) begin
         chk("strobe_excl", {31'b0, data_valid & frame_err}, 0);
         chk("strobe_width", {31'b0, prev_strobe}, 0);
         chk("sb_has_entry", {31'b0, sb.size() != 0}, 1);
         if (sb.size() != 0) begin
            m_e = sb.pop_front();
            chk("strobe_kind", {31'b0, frame_err}, {31'b0, m_e.is_err});
            chk("data_out", {27'b0, data_out}, {27'b0, m_e.data});
            chk("latency", cyc, m_e.at);
         end
      end
      prev_strobe = data_valid | frame_err;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      serial_in = 1'b1;
      step(3);
      chk("rst_data_out", {27'b0, data_out}, 0);
      chk("rst_valid", {31'b0, data_valid}, 0);
      chk("rst_err", {31'b0, frame_err}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      serial_in = 1'b0;
      rst_n     = 1'b1;
      step(40);
      chk("post_rst_busy", {31'b0, busy}, 0);

      send_frame(5'b10110, 1'b0, 1'b0);
      chk("good_hold", {27'b0, data_out}, {27'b0, 5'b10110});
      send_frame(5'b00000, 1'b0, 1'b0);
      send_frame(5'b11111, 1'b0, 1'b0);

      send_frame(5'b00011, 1'b1, 1'b0);
      chk("par_err_hold", {27'b0, data_out}, {27'b0, 5'b11111});

      send_frame(5'b10101, 1'b0, 1'b1);
      step(50);
      chk("stuck_high_busy", {31'b0, busy}, 0);
      serial_in = 1'b0;
      step(20);
      send_frame(5'b01001, 1'b0, 1'b0);

      serial_in = 1'b1;
      step(5);
      serial_in = 1'b0;
      step(3);
      chk("glitch_busy_hi", {31'b0, busy}, 1);
      step(10);
      chk("glitch_busy_lo", {31'b0, busy}, 0);

      serial_in = 1'b1;
      step(BT * 4 + BT / 2);
      chk("abort_busy_pre", {31'b0, busy}, 1);
      rst_n = 1'b0;
      step(3);
      last_good = '0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_data_out", {27'b0, data_out}, 0);
      serial_in = 1'b0;
      rst_n     = 1'b1;
      step(30);
      chk("abort_idle", {31'b0, busy}, 0);
      send_frame(5'b00101, 1'b0, 1'b0);

      step(7);
      for (int i = 0; i < 4; i++) begin
         send_frame(5'($urandom_range(0, 31)), 1'b0, 1'b0);
      end
      step(20);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
